// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, handshake levels,
// execute-stage aluop codes and the double-width result bus.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef logic [2*DIV_DATA_W-1:0] DoubleRegBus;

endpackage

// File: rtl/div_unit_negate.sv
// Conditional two's-complement, used to take operand magnitudes on entry
// and to restore quotient/remainder signs on exit.
module div_unit_negate #(
  parameter int W = 32
) (
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = en_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result presented as {remainder, quotient} and held while start_i stays high.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                sgn_q, sgn_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                op1_neg, op2_neg;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  logic [DATA_W:0]     trial;

  assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];

  div_unit_negate #(.W(DATA_W)) u_neg_op1 (.en_i(op1_neg), .val_i(opdata1_i), .val_o(op1_abs));
  div_unit_negate #(.W(DATA_W)) u_neg_op2 (.en_i(op2_neg), .val_i(opdata2_i), .val_o(op2_abs));

  div_unit_negate #(.W(DATA_W)) u_neg_quo (
    .en_i (sgn_q & neg_quo_q),
    .val_i(dividend_q[DATA_W-1:0]),
    .val_o(quo_fix)
  );
  div_unit_negate #(.W(DATA_W)) u_neg_rem (
    .en_i (sgn_q & neg_rem_q),
    .val_i(dividend_q[2*DATA_W:DATA_W+1]),
    .val_o(rem_fix)
  );

  // Partial remainder lives one bit above the quotient field, so the first
  // trial already sees the dividend MSB and the remainder ends at [2W:W+1].
  assign trial = {1'b0, dividend_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sgn_d      = sgn_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          sgn_d      = signed_div_i;
          neg_quo_d  = opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
          neg_rem_d  = opdata1_i[DATA_W-1];
          divisor_d  = op2_abs;
          dividend_d = {{DATA_W{1'b0}}, op1_abs, 1'b0};
          cnt_d      = '0;
          state_d    = (opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          if (trial[DATA_W])
            dividend_d = {dividend_q[2*DATA_W-1:0], 1'b0};
          else
            dividend_d = {trial[DATA_W-1:0], dividend_q[DATA_W-1:0], 1'b1};
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sgn_q      <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sgn_q      <= sgn_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed corner cases plus random DIV/DIVU,
// expected results from plain integer arithmetic.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!s) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest outstanding request
  initial begin : monitor
    logic prev;
    logic [63:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_o === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got result %h expected no response", result_o);
        end else begin
          e = exp_q.pop_front();
          chk("scoreboard_result", result_o, e);
        end
      end
      prev = (ready_o === 1'b1);
    end
  end

  task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] e;
    e = ref_div(s, a, b);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~s;
    n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n <= 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    repeat (2) begin
      @(negedge clk);
      chk("hold_ready", 64'(ready_o), 64'd1);
      chk("hold_result", result_o, e);
    end
    start_i = 1'b0;
    @(negedge clk);
    chk("drop_ready", 64'(ready_o), 64'd0);
    chk("drop_result", result_o, 64'd0);
  endtask

  task automatic quiet_window(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a, b;
    bit s;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;

    do_div(1'b0, 32'd100, 32'd7);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b0, 32'h1234_5678, 32'd0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
    do_div(1'b1, 32'h8000_0000, 32'd0);

    // annul during ON at E10
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0; start_i = 1'b0;
    quiet_window("annul_on_no_ready", 45);
    do_div(1'b0, 32'd9, 32'd4);

    // annul in FREE blocks acceptance
    @(negedge clk);
    opdata1_i = 32'd20; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    quiet_window("annul_free_no_ready", 40);
    start_i = 1'b0; annul_i = 1'b0;

    // annul during BYZERO
    @(negedge clk);
    opdata1_i = 32'd20; opdata2_i = 32'd0; start_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0; start_i = 1'b0;
    quiet_window("annul_byzero_no_ready", 5);

    // reset at E20 mid-division
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd67; start_i = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 64'(ready_o), 64'd0);
    chk("midreset_result", result_o, 64'd0);
    rst = 1'b0;
    quiet_window("midreset_no_ready", 40);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_div(s, a, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
